// File: rtl/hdmi_quad_wr_sched.sv
// Round-robin write scheduler: merges four quadrant line FIFOs onto one burst write port,
// placing channel n in quadrant n of the frame buffer.
module hdmi_quad_wr_sched #(
    parameter int H_ACT     = 960,
    parameter int V_ACT     = 540,
    parameter int STRIDE    = 1920,
    parameter int BURST_LEN = 64,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 28,
    parameter int CNT_W     = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ctrl_en_i,
    input  logic [3:0]          ch_frame_start_i,
    input  logic [4*CNT_W-1:0]  ch_fifo_cnt_i,
    input  logic [4*24-1:0]     ch_rd_data_i,
    output logic [3:0]          ch_rd_en_o,
    output logic                wr_cmd_valid_o,
    input  logic                wr_cmd_ready_i,
    output logic [ADDR_W-1:0]   wr_cmd_addr_o,
    output logic [7:0]          wr_cmd_len_o,
    output logic                wr_data_valid_o,
    input  logic                wr_data_ready_i,
    output logic [23:0]         wr_data_o,
    output logic                wr_data_last_o,
    output logic [3:0]          ch_frame_done_o,
    output logic                busy_o
);
    localparam int BPL    = H_ACT / BURST_LEN;
    localparam int LINE_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int BRST_W = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state_q, state_d;
    logic [1:0]        g_q, g_d, ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] line_q [4];
    logic [BRST_W-1:0] burst_q [4];
    logic [3:0]        pend_q, done_q;
    logic [3:0]        req;
    logic              gnt_vld;
    logic [1:0]        gnt;
    logic              last_beat, cmpl;
    logic [LINE_W-1:0] line_eff;
    logic [BRST_W-1:0] burst_eff;
    logic [ADDR_W-1:0] addr_calc;

    always_comb begin
        for (int n = 0; n < 4; n++)
            req[n] = ch_fifo_cnt_i[n*CNT_W +: CNT_W] >= CNT_W'(BURST_LEN);
    end

    always_comb begin : arb
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt     = ptr_q;
        idx     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    // A frame start landing on the grant cycle already counts, so the burst goes to line 0.
    always_comb begin
        line_eff  = ch_frame_start_i[gnt] ? '0 : line_q[gnt];
        burst_eff = ch_frame_start_i[gnt] ? '0 : burst_q[gnt];
        addr_calc = ADDR_W'(BASE_ADDR)
                  + (ADDR_W'(gnt[1]) * ADDR_W'(V_ACT) + ADDR_W'(line_eff)) * ADDR_W'(STRIDE)
                  + ADDR_W'(gnt[0]) * ADDR_W'(H_ACT)
                  + ADDR_W'(burst_eff) * ADDR_W'(BURST_LEN);
    end

    assign last_beat = (state_q == DATA) && (beat_q == BEAT_W'(BURST_LEN-1));
    assign cmpl      = last_beat && wr_data_ready_i;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (ctrl_en_i && gnt_vld) begin
                state_d = CMD;
                g_d     = gnt;
                addr_d  = addr_calc;
                beat_d  = '0;
            end
            CMD: if (wr_cmd_ready_i) state_d = DATA;
            DATA: if (wr_data_ready_i) begin
                if (last_beat) begin
                    state_d = IDLE;
                    ptr_d   = g_q + 2'd1;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
        end
    end

    // Frame starts on the in-flight channel are parked until its burst retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            done_q <= '0;
            for (int n = 0; n < 4; n++) begin
                line_q[n]  <= '0;
                burst_q[n] <= '0;
            end
        end else begin
            done_q <= '0;
            for (int n = 0; n < 4; n++) begin
                if (cmpl && g_q == 2'(n)) begin
                    if (pend_q[n] || ch_frame_start_i[n]) begin
                        line_q[n]  <= '0;
                        burst_q[n] <= '0;
                        pend_q[n]  <= 1'b0;
                    end else if (burst_q[n] == BRST_W'(BPL-1)) begin
                        burst_q[n] <= '0;
                        if (line_q[n] == LINE_W'(V_ACT-1)) begin
                            line_q[n] <= '0;
                            done_q[n] <= 1'b1;
                        end else begin
                            line_q[n] <= line_q[n] + LINE_W'(1);
                        end
                    end else begin
                        burst_q[n] <= burst_q[n] + BRST_W'(1);
                    end
                end else if (ch_frame_start_i[n]) begin
                    if (state_q != IDLE && g_q == 2'(n)) begin
                        pend_q[n] <= 1'b1;
                    end else begin
                        line_q[n]  <= '0;
                        burst_q[n] <= '0;
                    end
                end
            end
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign wr_cmd_valid_o  = (state_q == CMD);
    assign wr_cmd_addr_o   = addr_q;
    assign wr_cmd_len_o    = 8'(BURST_LEN-1);
    assign wr_data_valid_o = (state_q == DATA);
    assign wr_data_o       = (state_q == DATA) ? ch_rd_data_i[g_q*24 +: 24] : 24'h0;
    assign wr_data_last_o  = last_beat;
    assign ch_rd_en_o      = (state_q == DATA && wr_data_ready_i) ? (4'b0001 << g_q) : 4'b0000;
    assign ch_frame_done_o = done_q;
endmodule

// File: tb/tb_hdmi_quad_wr_sched.sv
// Scoreboard bench for hdmi_quad_wr_sched: modelled FIFOs, random back-pressure, burst-level reference.
module tb_hdmi_quad_wr_sched;
    localparam int H     = 960;
    localparam int V     = 6;      // short frames so a full frame wrap fits in the run
    localparam int S     = 1920;
    localparam int BL    = 64;
    localparam int BPL   = H / BL;
    localparam int CNT_W = 11;
    localparam int AW    = 28;

    logic              clk, rst, ctrl_en;
    logic [3:0]        ch_frame_start;
    logic [4*CNT_W-1:0] ch_fifo_cnt;
    logic [4*24-1:0]   ch_rd_data;
    logic [3:0]        ch_rd_en;
    logic              wr_cmd_valid, wr_cmd_ready;
    logic [AW-1:0]     wr_cmd_addr;
    logic [7:0]        wr_cmd_len;
    logic              wr_data_valid, wr_data_ready;
    logic [23:0]       wr_data;
    logic              wr_data_last;
    logic [3:0]        ch_frame_done;
    logic              busy;

    hdmi_quad_wr_sched #(.H_ACT(H), .V_ACT(V), .STRIDE(S), .BURST_LEN(BL),
                         .BASE_ADDR(0), .ADDR_W(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ctrl_en_i(ctrl_en), .ch_frame_start_i(ch_frame_start),
        .ch_fifo_cnt_i(ch_fifo_cnt), .ch_rd_data_i(ch_rd_data), .ch_rd_en_o(ch_rd_en),
        .wr_cmd_valid_o(wr_cmd_valid), .wr_cmd_ready_i(wr_cmd_ready),
        .wr_cmd_addr_o(wr_cmd_addr), .wr_cmd_len_o(wr_cmd_len),
        .wr_data_valid_o(wr_data_valid), .wr_data_ready_i(wr_data_ready),
        .wr_data_o(wr_data), .wr_data_last_o(wr_data_last),
        .ch_frame_done_o(ch_frame_done), .busy_o(busy)
    );

    typedef struct {int ch; int addr; bit done;} rec_t;
    rec_t exp_q[$];

    int errors, checks;
    int fill_req[4], popped[4];
    int stall_mode;
    bit mon_en;
    logic [3:0] pop_mask;

    // reference model state: bursts written since frame start, and the round-robin pointer
    int m_k[4];
    int m_ptr;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] pix(int ch, int k);
        logic [31:0] v;
        v = k * 32'd40503 + ch * 32'd7919 + 32'h5a5a5;
        v = v ^ (v >> 11);
        return 24'(v) ^ (24'(ch) << 22);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // FIFO environment: pops follow handshakes seen at the previous negedge
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            int lvl;
            if (pop_mask[c]) popped[c]++;
            lvl = fill_req[c] - popped[c];
            ch_fifo_cnt[c*CNT_W +: CNT_W] = (lvl > 2047) ? 11'd2047 : 11'(lvl);
            ch_rd_data[c*24 +: 24] = pix(c, popped[c]);
        end
        wr_data_ready = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_cmd_ready  = (stall_mode == 1) ? 1'($urandom_range(0, 1)) :
                        (stall_mode == 2) ? 1'b0 : 1'b1;
    end

    // monitor / scoreboard
    rec_t cur;
    bit   in_burst, cmd_wait;
    int   beat, idx[4];
    logic [AW-1:0] hold_addr;
    logic [3:0] done_exp;

    always @(negedge clk) begin
        pop_mask = ch_rd_en;
        if (!mon_en) begin
            in_burst = 0;
            cmd_wait = 0;
            done_exp = '0;
        end else begin
            if ((ch_frame_done | done_exp) != 0) chk("frame_done", 32'(ch_frame_done), 32'(done_exp));
            done_exp = '0;
            if (wr_cmd_valid) begin
                if (cmd_wait) chk("cmd_addr_hold", 32'(wr_cmd_addr), 32'(hold_addr));
                if (wr_cmd_ready) begin
                    cmd_wait = 0;
                    if (exp_q.size() == 0 || in_burst) fail("unexpected_cmd");
                    else begin
                        cur = exp_q.pop_front();
                        chk("cmd_addr", 32'(wr_cmd_addr), 32'(cur.addr));
                        chk("cmd_len", 32'(wr_cmd_len), 32'(BL-1));
                        in_burst = 1;
                        beat = 0;
                    end
                end else if (!cmd_wait) begin
                    cmd_wait = 1;
                    hold_addr = wr_cmd_addr;
                end
            end
            if (wr_data_valid) begin
                if (!in_burst) fail("data_without_cmd");
                else if (wr_data_ready) begin
                    chk("data", 32'(wr_data), 32'(pix(cur.ch, idx[cur.ch])));
                    chk("rd_en", 32'(ch_rd_en), 32'(4'b0001 << cur.ch));
                    chk("last", 32'(wr_data_last), 32'(beat == BL-1));
                    idx[cur.ch]++;
                    beat++;
                    if (beat == BL) begin
                        in_burst = 0;
                        done_exp = cur.done ? (4'b0001 << cur.ch) : 4'b0000;
                    end
                end else if (ch_rd_en != 0) fail("rd_en_while_stalled");
            end else if (ch_rd_en != 0) fail("stray_rd_en");
        end
    end

    task automatic push_burst(int ch);
        rec_t r;
        int k;
        k = m_k[ch] % (BPL * V);
        r.ch   = ch;
        r.addr = (ch / 2) * V * S + (k / BPL) * S + (ch % 2) * H + (k % BPL) * BL;
        r.done = (k == BPL * V - 1);
        m_k[ch] = k + 1;
        exp_q.push_back(r);
    endtask

    // predicts grant order for bursts made available all at once, then fills the FIFOs
    task automatic sched_fill(int b0, int b1, int b2, int b3);
        int b[4];
        int left;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        left = b0 + b1 + b2 + b3;
        while (left > 0) begin
            for (int i = 0; i < 4; i++) begin
                int n;
                n = (m_ptr + i) % 4;
                if (b[n] > 0) begin
                    push_burst(n);
                    b[n]--;
                    left--;
                    m_ptr = (n + 1) % 4;
                    break;
                end
            end
        end
        fill_req[0] += b0 * BL; fill_req[1] += b1 * BL;
        fill_req[2] += b2 * BL; fill_req[3] += b3 * BL;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_burst || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail("timeout_wait_idle");
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_fs(int ch);
        @(posedge clk); #2;
        ch_frame_start = 4'b0001 << ch;
        @(posedge clk); #2;
        ch_frame_start = 4'b0000;
    endtask

    initial begin
        int n, save;
        errors = 0; checks = 0;
        rst = 1; ctrl_en = 0; ch_frame_start = 0; stall_mode = 0; mon_en = 1;
        pop_mask = 0; m_ptr = 0; in_burst = 0; cmd_wait = 0; done_exp = 0; beat = 0;
        for (int c = 0; c < 4; c++) begin
            fill_req[c] = 0; popped[c] = 0; m_k[c] = 0; idx[c] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 32'(wr_cmd_valid), 0);
        chk("rst_data_valid", 32'(wr_data_valid), 0);
        chk("rst_rd_en", 32'(ch_rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(wr_cmd_addr), 0);
        chk("rst_len", 32'(wr_cmd_len), BL-1);
        chk("rst_last", 32'(wr_data_last), 0);
        chk("rst_done", 32'(ch_frame_done), 0);
        @(posedge clk); #2;
        rst = 0; ctrl_en = 1;

        // one word short of a burst must not request
        fill_req[0] += BL - 1;
        repeat (20) @(negedge clk);
        chk("below_threshold_busy", 32'(busy), 0);
        chk("below_threshold_cmd", 32'(wr_cmd_valid), 0);
        exp_q.push_back('{ch: 0, addr: 0, done: 0});
        m_k[0] = 1; m_ptr = 1;
        fill_req[0] += 1;
        wait_idle(500);
        chk("single_busy_after", 32'(busy), 0);

        // round robin over all channels
        sched_fill(2, 1, 1, 1);
        wait_idle(2000);

        // random back-pressure and random burst mixes
        stall_mode = 1;
        for (int r = 0; r < 3; r++) begin
            sched_fill($urandom_range(0, 4), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 4));
            wait_idle(6000);
        end
        stall_mode = 0;

        // frame start while channel 1 is mid-burst at line 3
        pulse_fs(1); m_k[1] = 0;
        sched_fill(0, 3 * BPL, 0, 0);
        wait_idle(6000);
        push_burst(1); m_k[1] = 0; push_burst(1); m_ptr = 2;
        fill_req[1] += 2 * BL;
        n = 0;
        while (!(in_burst && cur.ch == 1 && beat >= 10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("timeout_fs_burst");
        pulse_fs(1);
        wait_idle(1000);

        // full frame on channel 3, then the first burst of the next frame
        pulse_fs(3); m_k[3] = 0;
        sched_fill(0, 0, 0, BPL * V + 1);
        wait_idle(9000);

        // ctrl_en dropped while a command is waiting
        stall_mode = 2;
        sched_fill(2, 0, 0, 0);
        n = 0;
        while (!wr_cmd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("timeout_cmd_valid");
        ctrl_en = 0;
        stall_mode = 0;
        repeat (300) @(negedge clk);
        chk("ctrl_off_remaining", 32'(exp_q.size()), 1);
        chk("ctrl_off_busy", 32'(busy), 0);
        ctrl_en = 1;
        wait_idle(1000);

        // reset in the middle of a data burst
        sched_fill(1, 0, 0, 0);
        n = 0;
        while (!(in_burst && beat >= 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail("timeout_rst_burst");
        @(posedge clk); #2;
        mon_en = 0;
        rst = 1;
        #1;
        chk("midrst_rd_en", 32'(ch_rd_en), 0);
        chk("midrst_data_valid", 32'(wr_data_valid), 0);
        chk("midrst_cmd_valid", 32'(wr_cmd_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        save = popped[0];
        repeat (10) @(negedge clk);
        ctrl_en = 0;
        rst = 0;
        repeat (20) @(negedge clk);
        chk("midrst_no_pops", popped[0], save);
        chk("midrst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
